// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default timing, colours, region classes and palette for the VGA grid renderer
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam logic [2:0] DEF_CLR_EMPTY  = 3'b000;
  localparam logic [2:0] DEF_CLR_BORDER = 3'b100;
  localparam logic [2:0] DEF_CLR_BG     = 3'b001;

  // Entry i lives at [i*3 +: 3]; entry 0 is the empty cell.
  localparam logic [23:0] DEF_PALETTE = {3'b001, 3'b100, 3'b111, 3'b010,
                                         3'b101, 3'b110, 3'b011, DEF_CLR_EMPTY};

  typedef enum logic [1:0] {REG_BLANK, REG_BG, REG_BORDER, REG_GRID} region_e;

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - h/v raster counters with registered sync, data-enable and frame-end flag
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic [HW-1:0] h_o,
  output logic [VW-1:0] v_o,
  output logic          line_end_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          de_o,
  output logic          frame_end_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [31:0]   hx, vx;
  logic          line_end, frame_end;
  logic          hsync_q, vsync_q, de_q, frame_end_q;

  always_comb begin
    hx        = 32'(h_q);
    vx        = 32'(v_q);
    line_end  = (hx == H_TOTAL - 1);
    frame_end = line_end && (vx == V_TOTAL - 1);
    h_d       = line_end ? '0 : h_q + HW'(1);
    v_d       = v_q;
    if (line_end) begin
      v_d = (vx == V_TOTAL - 1) ? '0 : v_q + VW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_q         <= '0;
      v_q         <= '0;
      hsync_q     <= ~HS_POL;
      vsync_q     <= ~VS_POL;
      de_q        <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      hsync_q     <= (hx >= H_ACTIVE + H_FP && hx < H_ACTIVE + H_FP + H_SYNC) ? HS_POL : ~HS_POL;
      vsync_q     <= (vx >= V_ACTIVE + V_FP && vx < V_ACTIVE + V_FP + V_SYNC) ? VS_POL : ~VS_POL;
      de_q        <= (hx < H_ACTIVE) && (vx < V_ACTIVE);
      frame_end_q <= frame_end;
    end
  end

  assign h_o         = h_q;
  assign v_o         = v_q;
  assign line_end_o  = line_end;
  assign hsync_o     = hsync_q;
  assign vsync_o     = vsync_q;
  assign de_o        = de_q;
  assign frame_end_o = frame_end_q;

endmodule

// File: rtl/vga_grid_renderer.sv
// rtl/vga_grid_renderer.sv - VGA raster, cell-grid walk and palette colouring with a 3-clock pipeline
// Define VGA_GRID_LINES_EN to draw 1-px cell separators in border colour.
module vga_grid_renderer
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int GRID_COLS  = 10,
  parameter int GRID_ROWS  = 20,
  parameter int CELL_W     = 20,
  parameter int CELL_H     = 20,
  parameter int GRID_X0    = 220,
  parameter int GRID_Y0    = 40,
  parameter int BORDER     = 8,
  parameter int COLOR_BITS = 1,
  parameter int VAL_W      = 3,
  parameter logic [(2**VAL_W)*3*COLOR_BITS-1:0] PALETTE = DEF_PALETTE,
  parameter logic [3*COLOR_BITS-1:0] CLR_BORDER = DEF_CLR_BORDER,
  parameter logic [3*COLOR_BITS-1:0] CLR_BG     = DEF_CLR_BG
) (
  input  logic                          vga_clk,
  input  logic                          rst,
  output logic [$clog2(GRID_COLS)-1:0]  cell_x,
  output logic [$clog2(GRID_ROWS)-1:0]  cell_y,
  output logic                          cell_req,
  input  logic [VAL_W-1:0]              cell_value,
  output logic [COLOR_BITS-1:0]         red,
  output logic [COLOR_BITS-1:0]         green,
  output logic [COLOR_BITS-1:0]         blue,
  output logic                          hsync,
  output logic                          vsync,
  output logic                          de,
  output logic                          frame_done
);

  localparam int HW    = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW    = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int RGB_W = 3 * COLOR_BITS;
  localparam int XW    = $clog2(GRID_COLS);
  localparam int YW    = $clog2(GRID_ROWS);
  localparam int SXW   = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int SYW   = (CELL_H > 1) ? $clog2(CELL_H) : 1;
  localparam int GX1   = GRID_X0 + GRID_COLS * CELL_W;
  localparam int GY1   = GRID_Y0 + GRID_ROWS * CELL_H;

  if (GRID_X0 < BORDER || GX1 + BORDER > H_ACTIVE) begin : g_bad_h
    $error("vga_grid_renderer: grid plus border does not fit horizontally");
  end
  if (GRID_Y0 < BORDER || GY1 + BORDER > V_ACTIVE) begin : g_bad_v
    $error("vga_grid_renderer: grid plus border does not fit vertically");
  end

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          line_end, hs_s1, vs_s1, de_s1, fe_s1;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .HW(HW), .VW(VW)
  ) u_timing (
    .clk_i(vga_clk), .rst_i(rst), .h_o(h), .v_o(v), .line_end_o(line_end),
    .hsync_o(hs_s1), .vsync_o(vs_s1), .de_o(de_s1), .frame_end_o(fe_s1)
  );

  logic [SXW-1:0] sub_x_q, sub_x_d;
  logic [SYW-1:0] sub_y_q, sub_y_d;
  logic [XW-1:0]  cx_q, cx_d, cell_x_q;
  logic [YW-1:0]  cy_q, cy_d, cell_y_q;
  logic [31:0]    hx, vx;
  logic           in_gx, in_gy, sep_s0, cell_req_q;
  region_e        region_s0, region1_q, region2_q;
  logic           sep1_q, sep2_q, hs2_q, vs2_q, de2_q, fe2_q;
  logic [RGB_W-1:0] rgb_d, rgb_q;
  logic           hs3_q, vs3_q, de3_q, fe3_q;

  // Sub-counters track the current counter position; stepping only while the next pixel is
  // still inside the grid makes them land on 0 at every grid entry without a divider.
  always_comb begin
    hx      = 32'(h);
    vx      = 32'(v);
    in_gx   = (hx >= GRID_X0) && (hx < GX1);
    in_gy   = (vx >= GRID_Y0) && (vx < GY1);
    sub_x_d = '0;
    cx_d    = '0;
    if (hx >= GRID_X0 && hx < GX1 - 1) begin
      sub_x_d = (sub_x_q == SXW'(CELL_W - 1)) ? '0 : sub_x_q + SXW'(1);
      cx_d    = (sub_x_q == SXW'(CELL_W - 1)) ? cx_q + XW'(1) : cx_q;
    end
    sub_y_d = sub_y_q;
    cy_d    = cy_q;
    if (line_end) begin
      sub_y_d = '0;
      cy_d    = '0;
      if (vx >= GRID_Y0 && vx < GY1 - 1) begin
        sub_y_d = (sub_y_q == SYW'(CELL_H - 1)) ? '0 : sub_y_q + SYW'(1);
        cy_d    = (sub_y_q == SYW'(CELL_H - 1)) ? cy_q + YW'(1) : cy_q;
      end
    end
  end

  always_comb begin
    region_s0 = REG_BG;
    if (hx >= H_ACTIVE || vx >= V_ACTIVE) begin
      region_s0 = REG_BLANK;
    end else if (in_gx && in_gy) begin
      region_s0 = REG_GRID;
    end else if (hx >= GRID_X0 - BORDER && hx < GX1 + BORDER &&
                 vx >= GRID_Y0 - BORDER && vx < GY1 + BORDER) begin
      region_s0 = REG_BORDER;
    end
`ifdef VGA_GRID_LINES_EN
    sep_s0 = (sub_x_q == '0 && cx_q != '0) || (sub_y_q == '0 && cy_q != '0);
`else
    sep_s0 = 1'b0;
`endif
  end

  always_comb begin
    rgb_d = CLR_BG;
    case (region2_q)
      REG_BLANK:  rgb_d = '0;
      REG_GRID:   rgb_d = sep2_q ? CLR_BORDER : PALETTE[32'(cell_value) * RGB_W +: RGB_W];
      REG_BORDER: rgb_d = CLR_BORDER;
      default:    rgb_d = CLR_BG;
    endcase
  end

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      sub_x_q <= '0;  sub_y_q <= '0;  cx_q <= '0;  cy_q <= '0;
      cell_x_q <= '0; cell_y_q <= '0; cell_req_q <= 1'b0;
      region1_q <= REG_BLANK; region2_q <= REG_BLANK;
      sep1_q <= 1'b0; sep2_q <= 1'b0;
      hs2_q <= ~HS_POL; vs2_q <= ~VS_POL; de2_q <= 1'b0; fe2_q <= 1'b0;
      rgb_q <= '0; hs3_q <= ~HS_POL; vs3_q <= ~VS_POL; de3_q <= 1'b0; fe3_q <= 1'b0;
    end else begin
      sub_x_q <= sub_x_d; sub_y_q <= sub_y_d; cx_q <= cx_d; cy_q <= cy_d;
      cell_req_q <= in_gx && in_gy;
      cell_x_q   <= (in_gx && in_gy) ? cx_q : '0;
      cell_y_q   <= (in_gx && in_gy) ? cy_q : '0;
      region1_q  <= region_s0;
      sep1_q     <= sep_s0;
      region2_q  <= region1_q;
      sep2_q     <= sep1_q;
      hs2_q <= hs_s1; vs2_q <= vs_s1; de2_q <= de_s1; fe2_q <= fe_s1;
      rgb_q <= rgb_d; hs3_q <= hs2_q; vs3_q <= vs2_q; de3_q <= de2_q; fe3_q <= fe2_q;
    end
  end

  assign cell_x             = cell_x_q;
  assign cell_y             = cell_y_q;
  assign cell_req           = cell_req_q;
  assign {red, green, blue} = rgb_q;
  assign hsync              = hs3_q;
  assign vsync              = vs3_q;
  assign de                 = de3_q;
  assign frame_done         = fe3_q;

endmodule

// File: tb/tb_vga_grid_renderer.sv
// tb/tb_vga_grid_renderer.sv - randomized-content bench for vga_grid_renderer against a raster model
module tb_vga_grid_renderer;

  localparam int HA = 640, HFP = 16, HSY = 96, HBP = 48, HT = 800;
  localparam int VA = 40, VFP = 1, VSY = 2, VBP = 2, VT = 45;
  localparam int COLS = 10, ROWS = 3, CW = 20, CH = 8, GX = 220, GY = 8, BD = 8;
  localparam logic [2:0] PAL [8] = '{3'b000, 3'b011, 3'b110, 3'b101,
                                     3'b010, 3'b111, 3'b100, 3'b001};
`ifdef VGA_GRID_LINES_EN
  localparam logic [2:0] SEP_RGB = 3'b100;
`else
  localparam logic [2:0] SEP_RGB = 3'b110;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cell_x;
  logic [1:0] cell_y;
  logic       cell_req;
  logic [2:0] cell_value = 3'b000;
  logic       red, green, blue, hsync, vsync, de, frame_done;
  logic [2:0] mem [0:15][0:3];

  int total = 0, bad = 0;
  int since = 0, cyc = 0;
  int hs_fall = -1, hs_len = 0, vs_len = 0, fd_last = -1, fd_cnt = 0;
  bit hs_prev = 1'b1, de_seen = 1'b0;

  vga_grid_renderer #(
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .GRID_ROWS(ROWS), .CELL_H(CH), .GRID_Y0(GY)
  ) dut (
    .vga_clk(clk), .rst(rst), .cell_x(cell_x), .cell_y(cell_y), .cell_req(cell_req),
    .cell_value(cell_value), .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .de(de), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Synchronous lookup storage: data for the presented address one clock later.
  always @(posedge clk) cell_value <= mem[cell_x][cell_y];

  always @(posedge clk or posedge rst) begin
    if (rst) since <= 0;
    else     since <= since + 1;
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // {rgb[2:0], hsync, vsync, de, frame_done} for screen position (h, v)
  function automatic logic [6:0] exp_pix(input int h, input int v);
    logic [2:0] c;
    logic hs, vs, en, fd;
    int col, row;
    en = (h < HA) && (v < VA);
    hs = !(h >= HA + HFP && h < HA + HFP + HSY);
    vs = !(v >= VA + VFP && v < VA + VFP + VSY);
    fd = (h == HT - 1) && (v == VT - 1);
    if (!en) c = 3'b000;
    else if (h >= GX && h < GX + COLS * CW && v >= GY && v < GY + ROWS * CH) begin
      col = (h - GX) / CW;
      row = (v - GY) / CH;
      c = PAL[mem[col][row]];
`ifdef VGA_GRID_LINES_EN
      if ((col != 0 && (h - GX) % CW == 0) || (row != 0 && (v - GY) % CH == 0)) c = 3'b100;
`endif
    end else if (h >= GX - BD && h < GX + COLS * CW + BD && v >= GY - BD && v < GY + ROWS * CH + BD)
      c = 3'b100;
    else c = 3'b001;
    return {c, hs, vs, en, fd};
  endfunction

  // {cell_req, cell_x[3:0], cell_y[1:0]} for screen position (h, v)
  function automatic logic [6:0] exp_cell(input int h, input int v);
    int col, row;
    if (h >= GX && h < GX + COLS * CW && v >= GY && v < GY + ROWS * CH) begin
      col = (h - GX) / CW;
      row = (v - GY) / CH;
      return {1'b1, 4'(col), 2'(row)};
    end
    return 7'b0;
  endfunction

  task automatic fill_mem();
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 4; y++)
        mem[x][y] = 3'($urandom_range(0, 7));
    mem[3][2] = 3'd5;
    mem[1][0] = 3'd2;
    mem[0][0] = 3'd0;
  endtask

  always @(negedge clk) begin
    int p, h, v;
    logic [6:0] dp, dc;
    cyc++;
    dp = {red, green, blue, hsync, vsync, de, frame_done};
    dc = {cell_req, cell_x, cell_y};
    if (rst) begin
      check("rst_pix", int'(dp), int'(7'b000_1_1_0_0));
      check("rst_cell", int'(dc), 0);
      hs_fall = -1; hs_len = 0; vs_len = 0; fd_last = -1; fd_cnt = 0;
      hs_prev = 1'b1; de_seen = 1'b0;
    end else begin
      if (since >= 1) begin
        p = since - 1; h = p % HT; v = (p / HT) % VT;
        check("cell", int'(dc), int'(exp_cell(h, v)));
        if (v == GY && h == 220) check("cell_220", int'(dc), int'(7'b1_0000_00));
        if (v == GY && h == 239) check("cell_239", int'(dc), int'(7'b1_0000_00));
        if (v == GY && h == 240) check("cell_240", int'(dc), int'(7'b1_0001_00));
        if (v == GY && h == 419) check("cell_419", int'(dc), int'(7'b1_1001_00));
        if (v == GY && h == 420) check("cell_420", int'(dc), 0);
      end
      if (since >= 3) begin
        p = since - 3; h = p % HT; v = (p / HT) % VT;
        check("pix", int'(dp), int'(exp_pix(h, v)));
        if (h == 285 && v == 26) check("px_val5", int'(dp[6:4]), int'(3'b111));
        if (h == 225 && v == 10) check("px_empty", int'(dp[6:4]), 0);
        if (h == 215 && v == 10) check("px_border", int'(dp[6:4]), int'(3'b100));
        if (h == 100 && v == 10) check("px_bg", int'(dp[6:4]), int'(3'b001));
        if (h == 700 && v == 10) check("px_blank", int'({dp[6:4], dp[1]}), 0);
        if (h == 240 && v == 10) check("px_sep", int'(dp[6:4]), int'(SEP_RGB));
        if (h == 241 && v == 10) check("px_nosep", int'(dp[6:4]), int'(3'b110));
        if (hs_prev && !hsync) begin
          if (hs_fall >= 0) check("hs_period", cyc - hs_fall, HT);
          hs_fall = cyc;
        end
        if (!hsync) hs_len++;
        else if (hs_len != 0) begin check("hs_low", hs_len, HSY); hs_len = 0; end
        if (!vsync) vs_len++;
        else if (vs_len != 0) begin check("vs_low", vs_len, VSY * HT); vs_len = 0; end
        if (frame_done) begin
          if (fd_last >= 0) check("fd_period", cyc - fd_last, HT * VT);
          fd_last = cyc;
          fd_cnt++;
        end
      end else begin
        check("pre_pix", int'(dp), int'(7'b000_1_1_0_0));
      end
      if (de && !de_seen) begin
        de_seen = 1'b1;
        check("first_de", since, 3);
      end
      hs_prev = hsync;
    end
  end

  initial begin
    logic [6:0] ep;
    fill_mem();
    ep = exp_pix(285, 26); check("m_val5", int'(ep[6:4]), int'(3'b111));
    ep = exp_pix(225, 10); check("m_empty", int'(ep[6:4]), 0);
    ep = exp_pix(215, 10); check("m_border", int'(ep[6:4]), int'(3'b100));
    ep = exp_pix(700, 10); check("m_blank", int'({ep[6:4], ep[1]}), 0);
    ep = exp_pix(660, 0);  check("m_hsync", int'(ep[3]), 0);
    ep = exp_pix(799, 44); check("m_fd", int'(ep[0]), 1);
    ep = exp_cell(240, 8); check("m_cell", int'(ep), int'(7'b1_0001_00));

    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    repeat ($urandom_range(1000, 3000)) @(negedge clk);
    #2 rst = 1'b1;
    fill_mem();
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    repeat (2 * HT * VT + 100) @(negedge clk);
    #2;
    check("fd_count", fd_cnt, 2);
    check("de_seen", int'(de_seen), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
